// File: rtl/sprite_line_dispatcher.sv
// rtl/sprite_line_dispatcher.sv - scans sprite descriptors per scanline and broadcasts texture-row beats
module sprite_line_dispatcher #(
  parameter int         SPRITE_COUNT = 8,
  parameter logic [3:0] BG_TEX_ID    = 4'hF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_line_req,
  input  logic [3:0]                      i_line_y,
  output logic                            o_busy,
  output logic                            o_line_done,
  input  logic                            i_desc_we,
  input  logic [$clog2(SPRITE_COUNT)-1:0] i_desc_idx,
  input  logic [22:0]                     i_desc_data,
  output logic                            o_desc_err,
  output logic                            o_tex_rd,
  output logic [7:0]                      o_tex_addr,
  input  logic [127:0]                    i_tex_data,
  output logic                            o_ena,
  output logic [127:0]                    o_texture_data,
  output logic [4:0]                      o_start_x,
  output logic [4:0]                      o_start_y,
  output logic [7:0]                      o_position_z
);

  localparam int IW = $clog2(SPRITE_COUNT);

  typedef enum logic [2:0] {IDLE, SCAN, WAIT, EMIT, BG_WAIT, BG_EMIT} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [3:0]    line_y;
  logic [22:0]   desc_mem [SPRITE_COUNT];

  logic [22:0] cur;
  logic        cur_valid;
  logic [3:0]  cur_tex;
  logic [7:0]  cur_z;
  logic [4:0]  cur_sx;
  logic [4:0]  cur_sy;
  logic [4:0]  row_diff;
  logic        hit;
  logic        last;

  // Bit 4 of the biased difference set means the line lies outside the sprite's 16 rows.
  always_comb begin
    cur       = desc_mem[idx];
    cur_valid = cur[22];
    cur_tex   = cur[21:18];
    cur_z     = cur[17:10];
    cur_sx    = cur[9:5];
    cur_sy    = cur[4:0];
    row_diff  = 5'd16 + {1'b0, line_y} - cur_sy;
    hit       = cur_valid && (cur_z != 8'd0) && (cur_sx != 5'd0) && !row_diff[4];
    last      = (idx == IW'(SPRITE_COUNT - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      line_y         <= 4'd0;
      o_busy         <= 1'b0;
      o_line_done    <= 1'b0;
      o_desc_err     <= 1'b0;
      o_tex_rd       <= 1'b0;
      o_tex_addr     <= 8'd0;
      o_ena          <= 1'b0;
      o_texture_data <= 128'd0;
      o_start_x      <= 5'd0;
      o_start_y      <= 5'd0;
      o_position_z   <= 8'd0;
      for (int i = 0; i < SPRITE_COUNT; i++) desc_mem[i] <= 23'd0;
    end else begin
      o_tex_rd    <= 1'b0;
      o_ena       <= 1'b0;
      o_line_done <= 1'b0;
      o_desc_err  <= 1'b0;

      if (i_desc_we) begin
        if (o_busy) o_desc_err <= 1'b1;
        else        desc_mem[i_desc_idx] <= i_desc_data;
      end

      case (state)
        IDLE: begin
          // busy stays up through the cycle carrying line_done
          if (o_busy) begin
            o_busy <= 1'b0;
          end else if (i_line_req) begin
            line_y <= i_line_y;
            idx    <= '0;
            o_busy <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            o_tex_rd   <= 1'b1;
            o_tex_addr <= {cur_tex, row_diff[3:0]};
            state      <= WAIT;
          end else if (last) begin
            o_tex_rd   <= 1'b1;
            o_tex_addr <= {BG_TEX_ID, line_y};
            state      <= BG_WAIT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        WAIT: state <= EMIT;
        EMIT: begin
          o_ena          <= 1'b1;
          o_texture_data <= i_tex_data;
          o_start_x      <= cur_sx;
          o_start_y      <= cur_sy;
          o_position_z   <= cur_z;
          if (last) begin
            o_tex_rd   <= 1'b1;
            o_tex_addr <= {BG_TEX_ID, line_y};
            state      <= BG_WAIT;
          end else begin
            idx   <= idx + 1'b1;
            state <= SCAN;
          end
        end
        BG_WAIT: state <= BG_EMIT;
        BG_EMIT: begin
          o_ena          <= 1'b1;
          o_texture_data <= i_tex_data;
          o_start_x      <= 5'h10;
          o_start_y      <= {1'b1, line_y};
          o_position_z   <= 8'd0;
          o_line_done    <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
